serial_frame_deserializer: RTL and testbench

- Downstream consumer of the 124-stage serial shift register's `data_out` bitstream.
- Hunts for a sync word in the serial stream, then collects the next FRAME_W payload bits into a parallel word.
- Presents each completed frame on a valid/ready handshake to the parallel datapath.
- One-entry output buffer; flags overflow when a frame completes while the buffer is still occupied.

---
 rtl/serial_frame_deserializer_pkg.sv | 17 +
 rtl/serial_frame_deserializer_sync_detector.sv | 59 +++++
 rtl/serial_frame_deserializer.sv | 180 ++++++++++++++++++
 tb/tb_serial_frame_deserializer.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/serial_frame_deserializer_pkg.sv
// serial_frame_deserializer_pkg
//   Shared definitions for the serial frame deserializer slice: FSM state
//   encodings and the default frame geometry / sync word.
//   No ports (package only).
package serial_frame_deserializer_pkg;

    typedef enum logic [1:0] {
        HUNT    = 2'd0,
        COLLECT = 2'd1,
        PARITY  = 2'd2
    } state_t;

    localparam int          FRAME_W_DEF      = 124;
    localparam int          SYNC_W_DEF       = 8;
    localparam logic [7:0]  SYNC_PATTERN_DEF = 8'hA5;

endpackage

// File: rtl/serial_frame_deserializer_sync_detector.sv
// sync_detector
//   Sliding-window detector for the frame sync word. Each valid bit shifts
//   into the window LSB; a match is reported combinationally on the cycle the
//   bit completing the pattern is sampled, once at least SYNC_W bits have been
//   seen since the last clear.
// Ports:
//   clk        in   clock, rising edge
//   reset      in   synchronous active-high reset
//   clear      in   empties the window and fill count (priority over shift)
//   data_in    in   serial bit
//   bit_valid  in   data_in qualifier
//   match      out  sync word completed by the bit sampled this cycle
module sync_detector #(
    parameter int                SYNC_W       = 8,
    parameter logic [SYNC_W-1:0] SYNC_PATTERN = 8'hA5
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic data_in,
    input  logic bit_valid,
    output logic match
);

    localparam int FILL_W = $clog2(SYNC_W + 1);

    logic [SYNC_W-1:0] window_q, window_d;
    logic [FILL_W-1:0] fill_q, fill_d;

    // Window slides by one bit per valid sample so overlapping sync words are
    // still found; the fill count saturates at SYNC_W.
    always_comb begin
        window_d = window_q;
        fill_d   = fill_q;
        if (clear) begin
            window_d = '0;
            fill_d   = '0;
        end else if (bit_valid) begin
            window_d = {window_q[SYNC_W-2:0], data_in};
            if (fill_q != FILL_W'(SYNC_W)) begin
                fill_d = fill_q + FILL_W'(1);
            end
        end
    end

    assign match = !clear && bit_valid &&
                   (fill_d == FILL_W'(SYNC_W)) && (window_d == SYNC_PATTERN);

    always_ff @(posedge clk) begin
        if (reset) begin
            window_q <= '0;
            fill_q   <= '0;
        end else begin
            window_q <= window_d;
            fill_q   <= fill_d;
        end
    end

endmodule

// File: rtl/serial_frame_deserializer.sv
// serial_frame_deserializer
//   Hunts for a sync word in a qualified serial bitstream, collects the next
//   FRAME_W payload bits (first bit ends up in the MSB) and offers the frame
//   through a one-entry valid/ready buffer. A frame completing while the
//   buffer is still occupied and not being read is dropped and sets a sticky
//   overflow flag.
// Optional feature (macro SERIAL_FRAME_PARITY_EN): an even-parity bit follows
//   the payload; the frame is delivered on the parity bit's edge, or dropped
//   with a one-cycle parity_err pulse when the check fails.
// Ports:
//   clk          in   clock, rising edge
//   reset        in   synchronous active-high reset
//   data_in      in   serial bit
//   bit_valid    in   data_in qualifier; no state changes when low
//   frame_data   out  buffered frame
//   frame_valid  out  frame_data holds an unconsumed frame
//   frame_ready  in   consumer accepts when frame_valid && frame_ready
//   in_sync      out  collecting payload or parity bit
//   overflow     out  sticky frame-dropped flag
//   parity_err   out  one-cycle parity failure pulse (0 without parity)
module serial_frame_deserializer
    import serial_frame_deserializer_pkg::*;
#(
    parameter int                FRAME_W      = FRAME_W_DEF,
    parameter int                SYNC_W       = SYNC_W_DEF,
    parameter logic [SYNC_W-1:0] SYNC_PATTERN = SYNC_PATTERN_DEF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               data_in,
    input  logic               bit_valid,
    output logic [FRAME_W-1:0] frame_data,
    output logic               frame_valid,
    input  logic               frame_ready,
    output logic               in_sync,
    output logic               overflow,
    output logic               parity_err
);

    localparam int COUNT_W = $clog2(FRAME_W + 1);

    state_t               state_q, state_d;
    logic [COUNT_W-1:0]   count_q, count_d;
    logic [FRAME_W-1:0]   acc_q, acc_d;
    logic [FRAME_W-1:0]   frame_data_q, frame_data_d;
    logic                 frame_valid_q, frame_valid_d;
    logic                 overflow_q, overflow_d;
    logic                 frameDone;
    logic [FRAME_W-1:0]   doneWord;
    logic                 consume;
    logic                 syncMatch;
    logic                 hunting;
`ifdef SERIAL_FRAME_PARITY_EN
    logic                 parity_err_q, parity_err_d;
`endif

    assign hunting = (state_q == HUNT);

    // The detector only sees bits while hunting and is held empty otherwise,
    // so every frame must be preceded by its own complete sync word.
    sync_detector #(
        .SYNC_W       (SYNC_W),
        .SYNC_PATTERN (SYNC_PATTERN)
    ) u_sync_detector (
        .clk       (clk),
        .reset     (reset),
        .clear     (!hunting),
        .data_in   (data_in),
        .bit_valid (bit_valid && hunting),
        .match     (syncMatch)
    );

    assign consume = frame_valid_q && frame_ready;

    // Next-state logic: frame assembly FSM followed by the output buffer.
    // A completed frame may load into the buffer on the same edge that the
    // consumer drains it.
    always_comb begin
        state_d       = state_q;
        count_d       = count_q;
        acc_d         = acc_q;
        frameDone     = 1'b0;
        doneWord      = acc_q;
        frame_data_d  = frame_data_q;
        frame_valid_d = frame_valid_q && !consume;
        overflow_d    = overflow_q;
`ifdef SERIAL_FRAME_PARITY_EN
        parity_err_d  = 1'b0;
`endif

        case (state_q)
            HUNT: begin
                if (syncMatch) begin
                    state_d = COLLECT;
                    count_d = '0;
                end
            end
            COLLECT: begin
                if (bit_valid) begin
                    acc_d = {acc_q[FRAME_W-2:0], data_in};
                    if (count_q == COUNT_W'(FRAME_W - 1)) begin
                        count_d = '0;
`ifdef SERIAL_FRAME_PARITY_EN
                        state_d = PARITY;
`else
                        state_d   = HUNT;
                        frameDone = 1'b1;
                        doneWord  = acc_d;
`endif
                    end else begin
                        count_d = count_q + COUNT_W'(1);
                    end
                end
            end
`ifdef SERIAL_FRAME_PARITY_EN
            PARITY: begin
                if (bit_valid) begin
                    state_d = HUNT;
                    if ((^acc_q ^ data_in) == 1'b0) begin
                        frameDone = 1'b1;
                        doneWord  = acc_q;
                    end else begin
                        parity_err_d = 1'b1;
                    end
                end
            end
`endif
            default: begin
                state_d = HUNT;
            end
        endcase

        if (frameDone) begin
            if (!frame_valid_q || consume) begin
                frame_data_d  = doneWord;
                frame_valid_d = 1'b1;
            end else begin
                overflow_d = 1'b1;
            end
        end
    end

    // State and buffer registers; reset discards any partial or pending frame.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= HUNT;
            count_q       <= '0;
            acc_q         <= '0;
            frame_data_q  <= '0;
            frame_valid_q <= 1'b0;
            overflow_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            count_q       <= count_d;
            acc_q         <= acc_d;
            frame_data_q  <= frame_data_d;
            frame_valid_q <= frame_valid_d;
            overflow_q    <= overflow_d;
        end
    end

`ifdef SERIAL_FRAME_PARITY_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            parity_err_q <= 1'b0;
        end else begin
            parity_err_q <= parity_err_d;
        end
    end
    assign parity_err = parity_err_q;
`else
    assign parity_err = 1'b0;
`endif

    assign frame_data  = frame_data_q;
    assign frame_valid = frame_valid_q;
    assign overflow    = overflow_q;
    assign in_sync     = (state_q == COLLECT) || (state_q == PARITY);

endmodule

// File: tb/tb_serial_frame_deserializer.sv
// tb_serial_frame_deserializer
//   Directed bench for serial_frame_deserializer with hand-computed frames.
//   Inputs change and outputs are sampled on the falling clock edge.
//   Parity-specific vectors are included when SERIAL_FRAME_PARITY_EN is set.
module tb_serial_frame_deserializer;

    localparam int FW = 124;

    logic          clk;
    logic          reset;
    logic          data_in;
    logic          bit_valid;
    logic [FW-1:0] frame_data;
    logic          frame_valid;
    logic          frame_ready;
    logic          in_sync;
    logic          overflow;
    logic          parity_err;

    int checks;
    int errors;

    logic [127:0] patA;
    logic [127:0] patB;
    logic [7:0]   syncWord;
    logic [12:0]  overlapStream;

    serial_frame_deserializer dut (
        .clk         (clk),
        .reset       (reset),
        .data_in     (data_in),
        .bit_valid   (bit_valid),
        .frame_data  (frame_data),
        .frame_valid (frame_valid),
        .frame_ready (frame_ready),
        .in_sync     (in_sync),
        .overflow    (overflow),
        .parity_err  (parity_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard stop in case the stimulus ever stalls.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog expired obs=timeout exp=finish");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string tag, input logic [127:0] obs,
                               input logic [127:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s obs=%h exp=%h", tag, obs, exp);
        end
    endtask

    // One cycle: drive at the falling edge, return at the next falling edge.
    task automatic applyStimulus(input logic b, input logic v);
        data_in   = b;
        bit_valid = v;
        @(posedge clk);
        @(negedge clk);
        bit_valid = 1'b0;
    endtask

    task automatic applyReset();
        reset     = 1'b1;
        bit_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic sendSync();
        for (int i = 7; i >= 0; i--) applyStimulus(syncWord[i], 1'b1);
    endtask

    // Payload first bit = payload[FW-1]; parity bit appended when enabled.
    task automatic sendFrame(input logic [127:0] payload, input bit gapped,
                             input bit readyOnLast);
        for (int i = 0; i < FW; i++) begin
            if (i == FW - 1) begin
                checkOutput("inSyncBeforeLast", {127'd0, in_sync}, 128'd1);
`ifndef SERIAL_FRAME_PARITY_EN
                if (readyOnLast) frame_ready = 1'b1;
`endif
            end
            applyStimulus(payload[FW-1-i], 1'b1);
            if (gapped && i != FW - 1) applyStimulus(~payload[FW-1-i], 1'b0);
        end
`ifdef SERIAL_FRAME_PARITY_EN
        if (readyOnLast) frame_ready = 1'b1;
        applyStimulus(^payload[FW-1:0], 1'b1);
`endif
        if (readyOnLast) frame_ready = 1'b0;
    endtask

    initial begin
        checks      = 0;
        errors      = 0;
        reset       = 1'b1;
        data_in     = 1'b0;
        bit_valid   = 1'b0;
        frame_ready = 1'b0;
        syncWord    = 8'hA5;
        overlapStream = 13'b1010010100101;
        patA = '0;
        patB = '0;
        // patA: 0xF0F0... starting at the MSB; patB: 1,0,1,0,... starting at the MSB
        for (int i = 0; i < FW; i++) begin
            patA[FW-1-i] = ((i / 4) % 2 == 0);
            patB[FW-1-i] = (i % 2 == 0);
        end

        @(negedge clk);
        applyReset();
        checkOutput("rstValid",   {127'd0, frame_valid}, 128'd0);
        checkOutput("rstInSync",  {127'd0, in_sync},     128'd0);
        checkOutput("rstOverflow",{127'd0, overflow},    128'd0);
        checkOutput("rstParity",  {127'd0, parity_err},  128'd0);
        checkOutput("rstData",    {4'd0, frame_data},    128'd0);

        // Sync then frame, consumer always ready.
        frame_ready = 1'b1;
        sendSync();
        checkOutput("syncInSync", {127'd0, in_sync}, 128'd1);
        sendFrame(patA, 1'b0, 1'b0);
        checkOutput("f1Valid",  {127'd0, frame_valid}, 128'd1);
        checkOutput("f1Data",   {4'd0, frame_data}, patA);
        checkOutput("f1Nibble", {124'd0, frame_data[123:120]}, 128'hF);
        checkOutput("f1InSync", {127'd0, in_sync}, 128'd0);
        applyStimulus(1'b0, 1'b0);
        checkOutput("f1Drained", {127'd0, frame_valid}, 128'd0);

        // Same stream with idle cycles between valid bits.
        sendSync();
        sendFrame(patA, 1'b1, 1'b0);
        checkOutput("gapValid", {127'd0, frame_valid}, 128'd1);
        checkOutput("gapData",  {4'd0, frame_data}, patA);
        applyStimulus(1'b0, 1'b0);
        checkOutput("gapDrained", {127'd0, frame_valid}, 128'd0);

        // Overflow: two frames with no reader.
        frame_ready = 1'b0;
        sendSync();
        sendFrame(patA, 1'b0, 1'b0);
        checkOutput("ovFirstValid", {127'd0, frame_valid}, 128'd1);
        checkOutput("ovNoFlagYet",  {127'd0, overflow}, 128'd0);
        sendSync();
        sendFrame(patB, 1'b0, 1'b0);
        checkOutput("ovValid", {127'd0, frame_valid}, 128'd1);
        checkOutput("ovKept",  {4'd0, frame_data}, patA);
        checkOutput("ovFlag",  {127'd0, overflow}, 128'd1);
        applyReset();
        checkOutput("ovRstFlag",  {127'd0, overflow}, 128'd0);
        checkOutput("ovRstValid", {127'd0, frame_valid}, 128'd0);

        // Read of the old frame on the same edge the new one completes.
        sendSync();
        sendFrame(patA, 1'b0, 1'b0);
        sendSync();
        sendFrame(patB, 1'b0, 1'b1);
        checkOutput("simValid", {127'd0, frame_valid}, 128'd1);
        checkOutput("simData",  {4'd0, frame_data}, patB);
        checkOutput("simFlag",  {127'd0, overflow}, 128'd0);
        frame_ready = 1'b1;
        applyStimulus(1'b0, 1'b0);
        checkOutput("simDrained", {127'd0, frame_valid}, 128'd0);

        // Near-miss prefix and overlap: match completes on bit 8.
        for (int i = 12; i >= 0; i--) begin
            applyStimulus(overlapStream[i], 1'b1);
            if (i == 6) checkOutput("ovlBit7", {127'd0, in_sync}, 128'd0);
            if (i == 5) checkOutput("ovlBit8", {127'd0, in_sync}, 128'd1);
        end
        // Five payload bits already sent; reach payload bit 60 then reset.
        for (int i = 0; i < 55; i++) applyStimulus(patB[FW-1-i], 1'b1);
        checkOutput("midInSync", {127'd0, in_sync}, 128'd1);
        applyReset();
        checkOutput("midRstInSync", {127'd0, in_sync}, 128'd0);
        // A sync-free stream must not produce a frame.
        for (int i = 0; i < FW + 8; i++) applyStimulus(patA[FW-1-(i % FW)], 1'b1);
        checkOutput("noSyncValid",  {127'd0, frame_valid}, 128'd0);
        checkOutput("noSyncInSync", {127'd0, in_sync}, 128'd0);
        sendSync();
        sendFrame(patB, 1'b0, 1'b0);
        checkOutput("resyncValid", {127'd0, frame_valid}, 128'd1);
        checkOutput("resyncData",  {4'd0, frame_data}, patB);
        applyStimulus(1'b0, 1'b0);

`ifdef SERIAL_FRAME_PARITY_EN
        // Flipped parity bit: frame dropped, single-cycle error pulse.
        sendSync();
        for (int i = 0; i < FW; i++) applyStimulus(patB[FW-1-i], 1'b1);
        checkOutput("parInSync", {127'd0, in_sync}, 128'd1);
        applyStimulus(~(^patB[FW-1:0]), 1'b1);
        checkOutput("parErr",     {127'd0, parity_err}, 128'd1);
        checkOutput("parValid",   {127'd0, frame_valid}, 128'd0);
        checkOutput("parInSync0", {127'd0, in_sync}, 128'd0);
        checkOutput("parOvf",     {127'd0, overflow}, 128'd0);
        applyStimulus(1'b0, 1'b0);
        checkOutput("parErrPulse", {127'd0, parity_err}, 128'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
